// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: ID/EXE/WB hooks of the issue-side scoreboard.
// master drives the pipeline side, slave is the scoreboard.
interface reg_scoreboard_if #(
  parameter int REG_FILE_ADDR_LEN = 4,
  parameter int REG_FILE_SIZE     = 16
);
  logic                         freeze;
  logic                         fwd_en;
  logic [REG_FILE_ADDR_LEN-1:0] src1_ID;
  logic [REG_FILE_ADDR_LEN-1:0] src2_ID;
  logic                         two_src_ID;
  logic                         src1_used_ID;
  logic                         issue_valid;
  logic                         issue_wb_en;
  logic [REG_FILE_ADDR_LEN-1:0] issue_dest;
  logic                         issue_mem_r_en;
  logic                         wb_valid;
  logic [REG_FILE_ADDR_LEN-1:0] wb_dest;
  logic                         hazard;
  logic [REG_FILE_SIZE-1:0]     busy_vec;
  logic                         sb_err;

  modport master (
    output freeze, fwd_en,
    output src1_ID, src2_ID,
    output two_src_ID, src1_used_ID,
    output issue_valid, issue_wb_en,
    output issue_dest, issue_mem_r_en,
    output wb_valid, wb_dest,
    input  hazard, busy_vec, sb_err
  );

  modport slave (
    input  freeze, fwd_en,
    input  src1_ID, src2_ID,
    input  two_src_ID, src1_used_ID,
    input  issue_valid, issue_wb_en,
    input  issue_dest, issue_mem_r_en,
    input  wb_valid, wb_dest,
    output hazard, busy_vec, sb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight write counters and
// load-in-EXE tracker driving the ID-stage stall.
module reg_scoreboard #(
  parameter int REG_FILE_ADDR_LEN = 4,
  parameter int REG_FILE_SIZE     = 16,
  parameter int CNT_LEN           = 2
) (
  input  logic           clk,
  input  logic           rst,
  reg_scoreboard_if.slave sb
);
  typedef logic [REG_FILE_ADDR_LEN-1:0] addr_t;
  typedef logic [CNT_LEN-1:0]           cnt_t;

  localparam cnt_t CNT_MAX = {CNT_LEN{1'b1}};

  cnt_t  cnt_q [REG_FILE_SIZE];
  cnt_t  cnt_d [REG_FILE_SIZE];
  logic  err_q, err_d;
  logic  ld_v_q, ld_v_d;
  addr_t ld_dest_q, ld_dest_d;
  logic  inc, dec;
  logic  m1, m2;

  assign inc = sb.issue_valid & sb.issue_wb_en;
  assign dec = sb.wb_valid;

  // Next-state counters with saturation and error capture.
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < REG_FILE_SIZE; r++) begin
      logic inc_r, dec_r;
      cnt_d[r] = cnt_q[r];
      inc_r = inc && (sb.issue_dest == addr_t'(r));
      dec_r = dec && (sb.wb_dest == addr_t'(r));
      if (inc_r && !dec_r) begin
        if (cnt_q[r] == CNT_MAX) err_d = 1'b1;
        else cnt_d[r] = cnt_q[r] + cnt_t'(1);
      end else if (dec_r && !inc_r) begin
        if (cnt_q[r] == '0) err_d = 1'b1;
        else cnt_d[r] = cnt_q[r] - cnt_t'(1);
      end
    end
    ld_v_d    = inc & sb.issue_mem_r_en;
    ld_dest_d = sb.issue_dest;
  end

  // State update; a frozen pipeline holds everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REG_FILE_SIZE; r++)
        cnt_q[r] <= '0;
      err_q     <= 1'b0;
      ld_v_q    <= 1'b0;
      ld_dest_q <= '0;
    end else if (!sb.freeze) begin
      for (int r = 0; r < REG_FILE_SIZE; r++)
        cnt_q[r] <= cnt_d[r];
      err_q     <= err_d;
      ld_v_q    <= ld_v_d;
      ld_dest_q <= ld_dest_d;
    end
  end

  // A source hits on a load in EXE when forwarding is on,
  // otherwise on any pending writer not retiring right now.
  function automatic logic hit(input addr_t s);
    logic retiring;
    retiring = sb.wb_valid && (sb.wb_dest == s)
            && (cnt_q[s] == cnt_t'(1));
    if (sb.fwd_en) return ld_v_q && (s == ld_dest_q);
    return (cnt_q[s] != '0) && !retiring;
  endfunction

  // Stall decision from the two ID source ports.
  always_comb begin
    m1 = sb.src1_used_ID & hit(sb.src1_ID);
    m2 = sb.two_src_ID & hit(sb.src2_ID);
  end

  assign sb.hazard = m1 | m2;
  assign sb.sb_err = err_q;

  // Busy flags straight from the registered counters.
  always_comb begin
    for (int r = 0; r < REG_FILE_SIZE; r++)
      sb.busy_vec[r] = (cnt_q[r] != '0);
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed scenarios with
// hand-computed stall, busy and error expectations.
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  reg_scoreboard_if sbif ();

  reg_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sbif.freeze         = 1'b0;
    sbif.src1_ID        = '0;
    sbif.src2_ID        = '0;
    sbif.two_src_ID     = 1'b0;
    sbif.src1_used_ID   = 1'b0;
    sbif.issue_valid    = 1'b0;
    sbif.issue_wb_en    = 1'b0;
    sbif.issue_dest     = '0;
    sbif.issue_mem_r_en = 1'b0;
    sbif.wb_valid       = 1'b0;
    sbif.wb_dest        = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    sbif.fwd_en = 1'b0;
    rst = 1'b0;
    #2;
    checks++;
    if (sbif.busy_vec !== 16'h0) begin
      errors++;
      $display("FAIL reset_busy got %h exp 0000",
               sbif.busy_vec);
    end
    checks++;
    if (sbif.hazard !== 1'b0) begin
      errors++;
      $display("FAIL reset_hazard got %b exp 0",
               sbif.hazard);
    end
    checks++;
    if (sbif.sb_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %b exp 0",
               sbif.sb_err);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_alu_fwd();
    do_reset();
    sbif.fwd_en      = 1'b1;
    sbif.issue_valid = 1'b1;
    sbif.issue_wb_en = 1'b1;
    sbif.issue_dest  = 4'd3;
    tick();
    idle();
    sbif.src1_used_ID = 1'b1;
    sbif.src1_ID      = 4'd3;
    #1;
    checks++;
    if (sbif.hazard !== 1'b0) begin
      errors++;
      $display("FAIL alu_fwd_hazard got %b exp 0",
               sbif.hazard);
    end
    checks++;
    if (sbif.busy_vec !== 16'h0008) begin
      errors++;
      $display("FAIL alu_fwd_busy got %h exp 0008",
               sbif.busy_vec);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    sbif.fwd_en         = 1'b1;
    sbif.issue_valid    = 1'b1;
    sbif.issue_wb_en    = 1'b1;
    sbif.issue_mem_r_en = 1'b1;
    sbif.issue_dest     = 4'd5;
    tick();
    idle();
    sbif.two_src_ID = 1'b1;
    sbif.src2_ID    = 4'd5;
    #1;
    checks++;
    if (sbif.hazard !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall got %b exp 1",
               sbif.hazard);
    end
    tick();
    checks++;
    if (sbif.hazard !== 1'b0) begin
      errors++;
      $display("FAIL load_use_release got %b exp 0",
               sbif.hazard);
    end
    checks++;
    if (sbif.busy_vec !== 16'h0020) begin
      errors++;
      $display("FAIL load_use_busy got %h exp 0020",
               sbif.busy_vec);
    end
  endtask

  task automatic test_no_fwd_raw();
    logic [2:0] exp_h;
    exp_h = 3'b011;
    do_reset();
    sbif.fwd_en      = 1'b0;
    sbif.issue_valid = 1'b1;
    sbif.issue_wb_en = 1'b1;
    sbif.issue_dest  = 4'd2;
    tick();
    idle();
    sbif.src1_used_ID = 1'b1;
    sbif.src1_ID      = 4'd2;
    for (int c = 0; c < 3; c++) begin
      sbif.wb_valid = (c == 2);
      sbif.wb_dest  = 4'd2;
      #1;
      checks++;
      if (sbif.hazard !== exp_h[c]) begin
        errors++;
        $display("FAIL raw_hazard c%0d got %b exp %b",
                 c, sbif.hazard, exp_h[c]);
      end
      checks++;
      if (sbif.busy_vec !== 16'h0004) begin
        errors++;
        $display("FAIL raw_busy c%0d got %h exp 0004",
                 c, sbif.busy_vec);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (sbif.busy_vec !== 16'h0) begin
      errors++;
      $display("FAIL raw_retired got %h exp 0000",
               sbif.busy_vec);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    sbif.issue_valid = 1'b1;
    sbif.issue_wb_en = 1'b1;
    sbif.issue_dest  = 4'd7;
    tick();
    sbif.wb_valid = 1'b1;
    sbif.wb_dest  = 4'd7;
    tick();
    idle();
    #1;
    checks++;
    if (sbif.busy_vec !== 16'h0080) begin
      errors++;
      $display("FAIL same_cycle_busy got %h exp 0080",
               sbif.busy_vec);
    end
    checks++;
    if (sbif.sb_err !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_err got %b exp 0",
               sbif.sb_err);
    end
    sbif.wb_valid = 1'b1;
    sbif.wb_dest  = 4'd7;
    tick();
    idle();
    #1;
    checks++;
    if (sbif.busy_vec !== 16'h0) begin
      errors++;
      $display("FAIL same_cycle_drain got %h exp 0000",
               sbif.busy_vec);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    sbif.fwd_en      = 1'b0;
    sbif.issue_valid = 1'b1;
    sbif.issue_wb_en = 1'b1;
    sbif.issue_dest  = 4'd1;
    tick();
    tick();
    tick();
    checks++;
    if (sbif.sb_err !== 1'b0) begin
      errors++;
      $display("FAIL sat_three_err got %b exp 0",
               sbif.sb_err);
    end
    tick();
    idle();
    #1;
    checks++;
    if (sbif.sb_err !== 1'b1) begin
      errors++;
      $display("FAIL sat_four_err got %b exp 1",
               sbif.sb_err);
    end
    sbif.src1_used_ID = 1'b1;
    sbif.src1_ID      = 4'd1;
    sbif.wb_valid     = 1'b1;
    sbif.wb_dest      = 4'd1;
    #1;
    checks++;
    if (sbif.hazard !== 1'b1) begin
      errors++;
      $display("FAIL sat_wb_hazard got %b exp 1",
               sbif.hazard);
    end
    tick();
    tick();
    checks++;
    if (sbif.busy_vec !== 16'h0002) begin
      errors++;
      $display("FAIL sat_two_wb got %h exp 0002",
               sbif.busy_vec);
    end
    tick();
    checks++;
    if (sbif.busy_vec !== 16'h0) begin
      errors++;
      $display("FAIL sat_three_wb got %h exp 0000",
               sbif.busy_vec);
    end
    sbif.wb_dest = 4'd4;
    tick();
    idle();
    #1;
    checks++;
    if (sbif.busy_vec !== 16'h0) begin
      errors++;
      $display("FAIL underflow_busy got %h exp 0000",
               sbif.busy_vec);
    end
    checks++;
    if (sbif.sb_err !== 1'b1) begin
      errors++;
      $display("FAIL underflow_err got %b exp 1",
               sbif.sb_err);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    sbif.wb_valid = 1'b1;
    sbif.wb_dest  = 4'd4;
    tick();
    idle();
    #1;
    checks++;
    if (sbif.sb_err !== 1'b1) begin
      errors++;
      $display("FAIL fresh_underflow got %b exp 1",
               sbif.sb_err);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    sbif.fwd_en         = 1'b1;
    sbif.issue_valid    = 1'b1;
    sbif.issue_wb_en    = 1'b1;
    sbif.issue_mem_r_en = 1'b1;
    sbif.issue_dest     = 4'd6;
    tick();
    idle();
    sbif.freeze       = 1'b1;
    sbif.src1_used_ID = 1'b1;
    sbif.src1_ID      = 4'd6;
    for (int i = 0; i < 6; i++) begin
      sbif.issue_valid = i[0];
      sbif.issue_wb_en = 1'b1;
      sbif.issue_dest  = 4'd9;
      sbif.wb_valid    = ~i[0];
      sbif.wb_dest     = 4'd6;
      #1;
      checks++;
      if (sbif.hazard !== 1'b1) begin
        errors++;
        $display("FAIL freeze_hazard i%0d got %b exp 1",
                 i, sbif.hazard);
      end
      checks++;
      if (sbif.busy_vec !== 16'h0040) begin
        errors++;
        $display("FAIL freeze_busy i%0d got %h exp 0040",
                 i, sbif.busy_vec);
      end
      tick();
    end
    sbif.freeze      = 1'b0;
    sbif.issue_valid = 1'b0;
    sbif.wb_valid    = 1'b0;
    #1;
    checks++;
    if (sbif.hazard !== 1'b1) begin
      errors++;
      $display("FAIL unfreeze_hazard got %b exp 1",
               sbif.hazard);
    end
    tick();
    checks++;
    if (sbif.hazard !== 1'b0) begin
      errors++;
      $display("FAIL bubble_clear got %b exp 0",
               sbif.hazard);
    end
    sbif.src1_used_ID = 1'b0;
    sbif.wb_valid     = 1'b1;
    sbif.wb_dest      = 4'd0;
    tick();
    checks++;
    if (sbif.sb_err !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_err got %b exp 1",
               sbif.sb_err);
    end
    sbif.fwd_en       = 1'b0;
    sbif.freeze       = 1'b1;
    sbif.issue_valid  = 1'b1;
    sbif.issue_dest   = 4'd6;
    sbif.src1_used_ID = 1'b1;
    sbif.src1_ID      = 4'd6;
    tick();
    #1;
    checks++;
    if (sbif.hazard !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_hazard got %b exp 1",
               sbif.hazard);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (sbif.busy_vec !== 16'h0) begin
      errors++;
      $display("FAIL rst_busy got %h exp 0000",
               sbif.busy_vec);
    end
    checks++;
    if (sbif.hazard !== 1'b0) begin
      errors++;
      $display("FAIL rst_hazard got %b exp 0",
               sbif.hazard);
    end
    checks++;
    if (sbif.sb_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_err got %b exp 0",
               sbif.sb_err);
    end
    rst = 1'b1;
    idle();
    tick();
  endtask

  initial begin
    idle();
    sbif.fwd_en = 1'b0;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_no_fwd_raw();
    test_same_cycle();
    test_saturate();
    test_underflow();
    test_freeze();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Issue-side register scoreboard for the 5-stage pipeline; it is the producer-side counterpart of the EXE-stage forwarding unit. It records every in-flight register write from the moment an instruction leaves ID until its WB-stage write retires. From that state it raises the ID-stage `hazard` (stall) signal: load-use stalls only when forwarding is enabled, and full RAW stalls when forwarding is disabled. It sits beside the ID/EXE pipeline register and drives the freeze of PC, IF/ID and the bubble insertion into ID/EXE.

## Interface
- `REG_FILE_ADDR_LEN`, 4, register address width
- `REG_FILE_SIZE`, 16, number of architectural registers tracked
- `CNT_LEN`, 2, width of per-register pending-write counter (max 3 in flight: EXE, MEM, WB)

- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: asynchronous, active-low reset
- `freeze` in 1: pipeline frozen (memory wait); all issue/retire inputs ignored, state held
- `fwd_en` in 1: 1 = forwarding unit active, 0 = forwarding disabled
- `src1_ID` in `REG_FILE_ADDR_LEN`: first source of instruction in ID
- `src2_ID` in `REG_FILE_ADDR_LEN`: second source (or store-data source) of instruction in ID
- `two_src_ID` in 1: instruction in ID reads `src2_ID`
- `src1_used_ID` in 1: instruction in ID reads `src1_ID`
- `issue_valid` in 1: ID instruction is accepted into ID/EXE this cycle (low on stall, flush or bubble)
- `issue_wb_en` in 1: issuing instruction writes a register
- `issue_dest` in `REG_FILE_ADDR_LEN`: destination of issuing instruction
- `issue_mem_r_en` in 1: issuing instruction is a load
- `wb_valid` in 1: WB stage writes the register file this cycle (`WB_EN_WB`)
- `wb_dest` in `REG_FILE_ADDR_LEN`: WB destination (`dest_WB`)
- `hazard` out 1: stall ID this cycle
- `busy_vec` out `REG_FILE_SIZE`: bit r = 1 when counter r ≠ 0
- `sb_err` out 1: sticky counter over/underflow flag

## Operation
- State:
  - `cnt[r]` (`CNT_LEN` bits) per register
  - `ld_exe_valid`, `ld_exe_dest`: the load currently in EXE
  - `sb_err`
- Counter update per edge, when `freeze`=0:
  - inc = `issue_valid & issue_wb_en`, applied to `issue_dest`; dec = `wb_valid`, applied to `wb_dest`.
  - inc and dec on the same register: counter unchanged.
  - inc on a register at 3 with no dec: counter saturates at 3 and `sb_err` is set.
  - dec on a register at 0: ignored and `sb_err` is set.
- Load tracker, when `freeze`=0:
  - `ld_exe_valid` <= `issue_valid & issue_wb_en & issue_mem_r_en`.
  - `ld_exe_dest` <= `issue_dest`.
  - Every unfrozen edge overwrites both, so a bubble clears `ld_exe_valid`.
- Source match: `m1` = `src1_used_ID` & src1 hit; `m2` = `two_src_ID` & src2 hit.
- `fwd_en`=1: hit on src = `ld_exe_valid & (src == ld_exe_dest)`. All other RAW cases are covered by forwarding.
- `fwd_en`=0:
  - Hit on src = `cnt[src] ≠ 0`, except when `wb_valid & wb_dest == src & cnt[src] == 1`. The register file writes in the first half-cycle, so a retiring single writer does not stall.
- `hazard` = `m1 | m2`. It is combinational from registered state and current ID/WB inputs, and is not gated by `freeze`.
- `busy_vec` is decoded from registered counters only.
- `sb_err` is cleared only by `rst`.

## Timing
- Reset (async assert, sync-safe release): all `cnt`=0, `ld_exe_valid`=0, `ld_exe_dest`=0, `sb_err`=0. Therefore `hazard`=0 and `busy_vec`=0.
- Issue at edge N: `busy_vec`, `cnt` and `ld_exe_valid` reflect the issue from edge N onward. `hazard` can be asserted in the cycle immediately following N.
- Load-use: with `fwd_en`=1, a load issued at edge N stalls a dependent ID instruction for exactly one cycle. The bubble at edge N+1 clears `ld_exe_valid`.
- Non-forwarding RAW: the stall lasts until the writer's WB cycle, with release in that same cycle. That is 2 stall cycles after a back-to-back dependency.
- `freeze`=1 for K cycles: state is identical before and after. `hazard` keeps its value as long as the inputs are unchanged.
- Reset mid-operation clears all pending counts immediately. The pipeline registers are reset by the same `rst`.

## Test plan
- Reset, then issue ADD r3 (wb_en), next cycle ID reads r3 with `fwd_en`=1 → `hazard`=0, `busy_vec`=0x0008.
- `fwd_en`=1, issue LDR r5, next cycle ID reads r5 as src2 with `two_src_ID`=1 → `hazard`=1 for exactly 1 cycle. `ld_exe_valid`=0 after the bubble.
- `fwd_en`=0, issue r2 writer, dependent in ID → `hazard`=1 for 2 cycles, 0 in the writer's WB cycle. `cnt[2]` goes 1,1,1 then 0 after WB.
- Same cycle issue to r7 and WB of r7 with `cnt[7]`=1 → `cnt[7]` stays 1, `sb_err`=0.
- Four consecutive r1 writers with no WB → `cnt[1]`=3 and `sb_err`=1. WB to r4 with `cnt[4]`=0 → ignored, `sb_err` stays 1.
- `freeze`=1 for 6 cycles with `issue_valid`=1 and `wb_valid`=1 toggling → counters and `ld_exe_valid` unchanged. Assert `rst`=0 mid-freeze → all outputs 0 immediately.
